load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle load/store unit sitting directly upstream of the register-file write port (we/waddr/wbdata).
//  Accepts one memory op at a time from execute via valid/ready and drives a word-wide data-memory request/grant/rvalid bus.
//  For loads it aligns and extends the returned data, then issues a single-cycle register-file write.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in WAIT for dmem_rvalid before abort with err; counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk           in   1   sole clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  req_valid     in   1   op valid from execute
//  req_ready     out  1   unit can accept op (high only in IDLE)
//  req_is_store  in   1   1=store, 0=load
//  req_funct3    in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data (low bits used for B/H)
//  req_rd        in   5   load destination register
//  dmem_req      out  1   memory request, held until dmem_gnt
//  dmem_we       out  1   1=write
//  dmem_addr     out  32  word address {req_addr[31:2],2'b00}
//  dmem_wdata    out  32  lane-replicated store data
//  dmem_be       out  4   byte enables
//  dmem_gnt      in   1   request accepted this cycle
//  dmem_rvalid   in   1   read data valid (earliest: cycle after gnt)
//  dmem_rdata    in   32  read word
//  rf_we         out  1   register-file write enable (1-cycle pulse)
//  rf_waddr      out  5   destination register
//  rf_wdata      out  32  aligned/extended load result
//  err           out  1   1-cycle pulse: misaligned, illegal funct3 or timeout
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; dmem_req, dmem_we, dmem_be, rf_we, err = 0; dmem_addr, dmem_wdata, rf_waddr, rf_wdata = 0; timeout counter = 0.
//  - FSM: IDLE, REQ, WAIT, WB. Registered op fields are captured on req_valid && req_ready.
//  - IDLE accept, legal op: -> REQ. Misaligned (H/HU/SH with addr[0]; W/SW with addr[1:0]!=0) or illegal funct3:
//    err=1 next cycle, no memory access, remain IDLE.
//  - REQ: dmem_req=1, all dmem_* outputs stable until gnt. On gnt: store -> IDLE; load -> WAIT (counter cleared).
//  - WAIT: on rvalid -> WB, latching aligned data. Otherwise increment counter.
//    At counter==TIMEOUT_CYCLES -1 without rvalid: err=1, -> IDLE, no rf write.
//  - WB: rf_we=1 (forced 0 if rd==0), rf_waddr=rd, rf_wdata valid; -> IDLE.
//  - Latency, load accepted at T with immediate gnt/rvalid: dmem_req T+1, WAIT T+2, rf_we T+3, req_ready T+4.
//  - Latency, store accepted at T with gnt at T+1: req_ready at T+2.
//  - Store lanes: SB wdata={4{b}}, be=4'b0001<<addr[1:0]; SH wdata={2{h}}, be=4'b0011<<addr[1:0]; SW be=4'b1111.
//  - Loads: select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
//  - rvalid outside WAIT and gnt outside REQ are ignored.
//  - req_valid while not ready is ignored; upstream holds the op.
//  - Reset asserted mid-operation aborts the op immediately: no rf_we, no err, IDLE on release.
//    A late rvalid after reset is ignored.
// STRUCTURE
//  - lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and typedef enum logic [1:0] lsu_state_t {IDLE, REQ, WAIT, WB}.
//  - Sub-module lsu_align (combinational): store lane replication/byte enables and load lane select/extend.
//    Instantiated once; FSM, capture registers and timeout counter stay in load_store_unit.
// TESTING
//  1. Reset, then LW addr=0x100 rd=5; memory word 0xDEADBEEF, gnt and rvalid immediate
//     -> rf_we at T+3, waddr=5, wdata=0xDEADBEEF.
//  2. LB addr=0x103 rdata=0x80FF_0000 -> wdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
//  3. SH addr=0x202 wdata=0x1234ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, dmem_we=1, no rf_we.
//  4. LW addr=0x101 -> err pulse one cycle, dmem_req never asserted, req_ready stays 1.
//  5. LW with rvalid withheld for TIMEOUT_CYCLES -> err pulse, no rf_we, next op accepted.
//     Same op with dmem_gnt delayed 3 cycles -> dmem_* stable throughout REQ.
//  6. Reset asserted in WAIT, then rvalid arrives -> no rf_we, outputs at reset values.
//     LW with rd=0 -> memory accessed, rf_we stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   F3_*          : funct3 encodings for memory access width / signedness
//   lsu_state_t   : control FSM states
//   lsu_op_legal  : true when an op may go to memory. It checks that funct3
//                   is legal for the direction and that the address is
//                   naturally aligned for the access size.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} lsu_state_t;

  function automatic logic lsu_op_legal(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !is_store;
      F3_H:    ok = !addr_lo[0];
      F3_HU:   ok = !is_store && !addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   funct3, addr_lo : captured access width and byte offset within the word
//   wdata           : store data (low byte/half used for B/H)
//   rdata           : word returned by memory
//   st_wdata/st_be  : lane-replicated store data and byte enables
//   ld_data         : selected and sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_wdata = wdata;
    st_be    = 4'b1111;
    case (funct3)
      F3_B: begin
        st_wdata = {4{wdata[7:0]}};
        st_be    = 4'b0001 << addr_lo;
      end
      F3_H: begin
        st_wdata = {2{wdata[15:0]}};
        st_be    = 4'b0011 << addr_lo;
      end
      default: begin
        st_wdata = wdata;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Move the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit feeding the register-file write port.
//   req_*   : one memory op from execute (valid/ready)
//   dmem_*  : word-wide data memory bus (req held until gnt; rvalid after gnt)
//   rf_*    : single-cycle register-file write for load results
//   err     : one-cycle pulse on misaligned/illegal op or read timeout
// Handshake: an op transfers on a cycle where req_valid && req_ready. A memory
// request transfers on a cycle where dmem_req && dmem_gnt, and dmem_* stays
// constant until then. dmem_rvalid counts only while waiting for read data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  state, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] rdata_q;
  logic [CW-1:0] cnt;
  logic        err_q;

  logic        accept;
  logic        legal;
  logic        timeout;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  assign accept  = req_valid && req_ready;
  assign legal   = lsu_op_legal(req_is_store, req_funct3, req_addr[1:0]);
  assign timeout = (state == WAIT) && !dmem_rvalid &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));

  lsu_align u_align (
    .funct3   (funct3_q),
    .addr_lo  (addr_q[1:0]),
    .wdata    (wdata_q),
    .rdata    (dmem_rdata),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept && legal) state_d = REQ;
      REQ:  if (dmem_gnt) state_d = is_store_q ? IDLE : WAIT;
      WAIT: begin
        if (dmem_rvalid)  state_d = WB;
        else if (timeout) state_d = IDLE;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rd_q       <= 5'd0;
      rdata_q    <= 32'd0;
      cnt        <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rd_q       <= req_rd;
      end
      // Counter restarts on every request so each WAIT gets a full budget.
      if (state == REQ)
        cnt <= '0;
      else if (state == WAIT && !dmem_rvalid && !timeout)
        cnt <= cnt + 1'b1;
      if (state == WAIT && dmem_rvalid)
        rdata_q <= ld_data;
      err_q <= (accept && !legal) || timeout;
    end
  end

  assign req_ready  = (state == IDLE);
  assign dmem_req   = (state == REQ);
  assign dmem_we    = (state == REQ) && is_store_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = st_wdata;
  // Loads read the whole word; lane selection happens on the way back.
  assign dmem_be    = (state != REQ) ? 4'b0000 : (is_store_q ? st_be : 4'b1111);
  // x0 is hardwired to zero, so a load into it performs the access but never writes.
  assign rf_we      = (state == WB) && (rd_q != 5'd0);
  assign rf_waddr   = rd_q;
  assign rf_wdata   = rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        rf_we, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  localparam int TMO = 16;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit known;
    known = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return known && (a % acc_size(f3) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] v;
    int sz;
    sz = acc_size(f3);
    v  = word >> (8 * (a % 4));
    if (sz == 4) return word;
    v = v % (32'd1 << (8 * sz));
    if (!f3[2] && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    return 4'(((1 << acc_size(f3)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_st_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    logic [31:0] r;
    sz = acc_size(f3);
    if (sz == 4) return d;
    r = 32'd0;
    for (int k = 0; k < 4 / sz; k++)
      r = r | ((d % (32'd1 << (8 * sz))) << (8 * sz * k));
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete op. gd = grant delay, rdly = rvalid delay, hold = never return data.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] word,
                       input int gd, input int rdly, input bit hold);
    int k;
    bit saw_we;
    logic [31:0] exp;
    k = 0;
    while (!req_ready && k < 40) begin step(); k++; end
    check("ready_before_op", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    step();
    req_valid = 1'b0;
    if (!ref_legal(st, f3, a)) begin
      check("illegal_err", {31'd0, err}, 32'd1);
      check("illegal_no_req", {31'd0, dmem_req}, 32'd0);
      check("illegal_ready", {31'd0, req_ready}, 32'd1);
      step();
      check("illegal_err_pulse", {31'd0, err}, 32'd0);
      return;
    end
    if (!st) exp_q.push_back(ref_load(f3, a, word));
    for (int g = 0; g <= gd; g++) begin
      check("req_held", {31'd0, dmem_req}, 32'd1);
      check("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
      check("req_we", {31'd0, dmem_we}, {31'd0, st});
      if (st) begin
        check("req_be", {28'd0, dmem_be}, {28'd0, ref_be(f3, a)});
        check("req_wdata", dmem_wdata, ref_st_wdata(f3, wd));
      end
      dmem_gnt = (g == gd);
      step();
    end
    dmem_gnt = 1'b0;
    if (st) begin
      check("store_ready", {31'd0, req_ready}, 32'd1);
      check("store_no_rf", {31'd0, rf_we}, 32'd0);
      return;
    end
    dmem_rdata = word;
    saw_we = 1'b0;
    if (hold) begin
      k = 0;
      while (!err && k < 40) begin
        saw_we |= rf_we;
        step();
        k++;
      end
      check("timeout_cycles", k, TMO);
      check("timeout_err", {31'd0, err}, 32'd1);
      check("timeout_ready", {31'd0, req_ready}, 32'd1);
      check("timeout_no_rf", {31'd0, saw_we}, 32'd0);
      void'(exp_q.pop_back());
      step();
      check("timeout_err_pulse", {31'd0, err}, 32'd0);
      return;
    end
    for (int r = 0; r <= rdly; r++) begin
      saw_we |= rf_we;
      dmem_rvalid = (r == rdly);
      step();
    end
    dmem_rvalid = 1'b0;
    dmem_rdata = $urandom;
    check("rf_no_early_we", {31'd0, saw_we}, 32'd0);
    check("rf_we", {31'd0, rf_we}, {31'd0, rd != 5'd0});
    exp = exp_q.pop_front();
    if (rd != 5'd0) begin
      check("rf_waddr", {27'd0, rf_waddr}, {27'd0, rd});
      check("rf_wdata", rf_wdata, exp);
    end
    step();
    check("rf_we_pulse", {31'd0, rf_we}, 32'd0);
    check("load_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_dreq"}, {31'd0, dmem_req}, 32'd0);
    check({tag, "_dwe"}, {31'd0, dmem_we}, 32'd0);
    check({tag, "_dbe"}, {28'd0, dmem_be}, 32'd0);
    check({tag, "_daddr"}, dmem_addr, 32'd0);
    check({tag, "_dwdata"}, dmem_wdata, 32'd0);
    check({tag, "_rfwe"}, {31'd0, rf_we}, 32'd0);
    check({tag, "_rfwaddr"}, {27'd0, rf_waddr}, 32'd0);
    check({tag, "_rfwdata"}, rf_wdata, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] f3_tab [7];
    bit st;
    logic [2:0] f3;
    logic [31:0] a;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    step(); step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Directed cases
    do_op(1'b0, 3'd2, 32'h100, 32'd0, 5'd5, 32'hDEADBEEF, 0, 0, 1'b0);
    do_op(1'b0, 3'd0, 32'h103, 32'd0, 5'd6, 32'h80FF_0000, 0, 0, 1'b0);
    do_op(1'b0, 3'd4, 32'h103, 32'd0, 5'd7, 32'h80FF_0000, 0, 0, 1'b0);
    do_op(1'b0, 3'd5, 32'h102, 32'd0, 5'd8, 32'h80FF_0000, 0, 0, 1'b0);
    do_op(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 5'd0, 32'd0, 0, 0, 1'b0);
    do_op(1'b0, 3'd2, 32'h101, 32'd0, 5'd5, 32'd0, 0, 0, 1'b0);
    do_op(1'b0, 3'd2, 32'h100, 32'd0, 5'd9, 32'h1111_2222, 0, 0, 1'b1);
    do_op(1'b0, 3'd2, 32'h104, 32'd0, 5'd9, 32'h3333_4444, 3, 0, 1'b0);
    do_op(1'b1, 3'd0, 32'h301, 32'hA5A5_A5C3, 5'd0, 32'd0, 3, 0, 1'b0);
    do_op(1'b0, 3'd2, 32'h108, 32'd0, 5'd0, 32'h5555_6666, 0, 1, 1'b0);

    // Reset while waiting for read data, followed by a late rvalid.
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h400; req_rd = 5'd3;
    step();
    req_valid = 1'b0; dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check("pre_reset_in_wait", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    step();
    reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    step();
    dmem_rvalid = 1'b0;
    check("late_rvalid_no_we", {31'd0, rf_we}, 32'd0);
    step();
    check_reset_outputs("after_late_rvalid");

    // Randomized ops
    for (int i = 0; i < 60; i++) begin
      st = $urandom_range(0, 2) == 0;
      f3 = f3_tab[$urandom_range(0, 6)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((acc_size(f3) == 4) ? 32'd3 : (acc_size(f3) == 2) ? 32'd1 : 32'd0);
      do_op(st, f3, a, $urandom, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
